// File: rtl/picomips_pkg.sv
// Shared opcode constants and controller state type for the picoMIPS core.
package picomips_pkg;

    localparam logic [2:0] OP_RTA  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_LSW  = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_ATR  = 3'b100;
    localparam logic [2:0] OP_MULI = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_WSW  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_EXEC    = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    // Opcodes that load the ALU accumulator.
    function automatic logic writes_acc(input logic [2:0] op);
        return (op == OP_RTA) || (op == OP_ADD) || (op == OP_LSW) ||
               (op == OP_ADDI) || (op == OP_MULI);
    endfunction

endpackage

// File: rtl/go_sync.sv
// Two-flop synchronizer bringing the operator Go switch into the Clock domain.
module go_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/seq_ctrl.sv
// picoMIPS sequencer: fetch/execute control, branching, halt and Go-switch wait.
//   state     | meaning
//   S_FETCH   | ROM presents Instr for current PC; all strobes low
//   S_EXEC    | decode Instr, fire one-cycle strobes, update PC
//   S_WAIT_HI | WSW: waiting for synchronized Go to rise
//   S_WAIT_LO | WSW: waiting for synchronized Go to fall, then PC+1
//   S_HALT    | JMP to self reached; frozen until Reset
module seq_ctrl
    import picomips_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int REG_AW = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       Instr,
    input  logic              Go,
    output logic [PC_W-1:0]   PC,
    output logic [2:0]        Func,
    output logic [7:0]        Imm,
    output logic [REG_AW-1:0] RegAddr,
    output logic              AluWE,
    output logic              SelSW,
    output logic              SelImm,
    output logic              RegWE,
    output logic              Halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            go_s;
    logic [2:0]      opcode;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jmp_tgt;

    go_sync u_go_sync (
        .Clock    (Clock),
        .Reset    (Reset),
        .async_in (Go),
        .sync_out (go_s)
    );

    assign opcode  = Instr[15:13];
    assign pc_inc  = pc_q + PC_W'(1);
    assign jmp_tgt = PC_W'(Instr[7:0]);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_JMP) begin
                    pc_d    = jmp_tgt;
                    state_d = (jmp_tgt == pc_q) ? S_HALT : S_FETCH;
                end else if (opcode == OP_WSW) begin
                    state_d = S_WAIT_HI;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_HI: begin
                if (go_s) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!go_s) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Decoded fields are forced to zero outside S_EXEC and while Reset is high.
    always_comb begin
        Func    = 3'b000;
        Imm     = 8'h00;
        RegAddr = '0;
        AluWE   = 1'b0;
        SelSW   = 1'b0;
        SelImm  = 1'b0;
        RegWE   = 1'b0;
        if (state_q == S_EXEC && !Reset) begin
            Func    = opcode;
            Imm     = Instr[7:0];
            RegAddr = REG_AW'(Instr[12:8]);
            AluWE   = writes_acc(opcode);
            SelSW   = (opcode == OP_LSW);
            SelImm  = (opcode == OP_ADDI) || (opcode == OP_MULI);
            RegWE   = (opcode == OP_ATR);
        end
    end

    assign PC     = pc_q;
    assign Halted = (state_q == S_HALT);

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: decode table, directed wait/jump/halt/wrap sequences, random programs.
module tb_seq_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Go    = 1'b0;
    logic [15:0] Instr = 16'h0000;
    logic [7:0]  PC;
    logic [2:0]  Func;
    logic [7:0]  Imm;
    logic [4:0]  RegAddr;
    logic        AluWE, SelSW, SelImm, RegWE, Halted;

    seq_ctrl #(.PC_W(8), .REG_AW(5)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Instr   (Instr),
        .Go      (Go),
        .PC      (PC),
        .Func    (Func),
        .Imm     (Imm),
        .RegAddr (RegAddr),
        .AluWE   (AluWE),
        .SelSW   (SelSW),
        .SelImm  (SelImm),
        .RegWE   (RegWE),
        .Halted  (Halted)
    );

    always #5 Clock = ~Clock;

    logic [15:0] rom [256];
    int nvec = 0;
    int nbad = 0;

    // {PC, Func, Imm, RegAddr, AluWE, SelSW, SelImm, RegWE, Halted}
    logic [28:0] act;
    assign act = {PC, Func, Imm, RegAddr, AluWE, SelSW, SelImm, RegWE, Halted};

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  func;
        logic        alu, sw, si, rwe;
        logic [7:0]  imm;
        logic [4:0]  ra;
        logic [7:0]  npc;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [28:0] idle_vec(input logic [7:0] pc, input logic h);
        return {pc, 3'b000, 8'h00, 5'd0, 4'b0000, h};
    endfunction

    // Reference decode of one instruction in the execute cycle.
    function automatic logic [28:0] exec_vec(input logic [7:0] pc, input logic [15:0] ins);
        logic [2:0] op;
        logic alu, sw, si, rwe;
        op  = ins[15:13];
        alu = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
        sw  = (op == 3'd2);
        si  = (op == 3'd3) || (op == 3'd5);
        rwe = (op == 3'd4);
        return {pc, op, ins[7:0], ins[12:8], alu, sw, si, rwe, 1'b0};
    endfunction

    // Synchronous ROM: Instr shows the word addressed by PC during the previous cycle.
    task automatic tick();
        logic [7:0] p;
        p = PC;
        @(posedge Clock);
        #1;
        Instr = rom[p];
        #1;
    endtask

    task automatic check(input string nm, input logic [28:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        check("reset", idle_vec(8'h00, 1'b0));
        Reset = 1'b0;
    endtask

    task automatic fill_add();
        for (int a = 0; a < 256; a++) rom[a] = 16'h2000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] pc, npc;
        logic [15:0] w;

        tbl[0] = '{16'h6005, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 5'd0,  8'h01};
        tbl[1] = '{16'h8700, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd7,  8'h01};
        tbl[2] = '{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  8'h01};
        tbl[3] = '{16'h3F81, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 5'd31, 8'h01};
        tbl[4] = '{16'h4A12, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 5'd10, 8'h01};
        tbl[5] = '{16'hA3FB, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFB, 5'd3,  8'h01};
        tbl[6] = '{16'h7480, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 5'd20, 8'h01};
        tbl[7] = '{16'hC020, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 5'd0,  8'h20};
        tbl[8] = '{16'hE1C3, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 5'd1,  8'h00};

        fill_add();
        for (int i = 0; i < 9; i++) begin
            rom[0] = tbl[i].instr;
            do_reset();
            tick();
            check($sformatf("tbl%0d_exec", i),
                  {8'h00, tbl[i].func, tbl[i].imm, tbl[i].ra,
                   tbl[i].alu, tbl[i].sw, tbl[i].si, tbl[i].rwe, 1'b0});
            tick();
            check($sformatf("tbl%0d_next", i), idle_vec(tbl[i].npc, 1'b0));
        end

        // Reset raised during an execute cycle must mask the strobes at once.
        rom[0] = 16'h6005;
        do_reset();
        tick();
        Reset = 1'b1;
        #1;
        nvec++;
        if ({AluWE, SelSW, SelImm, RegWE} !== 4'b0000) begin
            nbad++;
            $display("FAIL rst_exec_strobes: got %b expected 0000", {AluWE, SelSW, SelImm, RegWE});
        end
        tick();
        check("rst_exec_after", idle_vec(8'h00, 1'b0));
        Reset = 1'b0;

        // WSW at PC=4 with Go handshake.
        fill_add();
        rom[4] = 16'hE000;
        Go = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        check("wsw_fetch", idle_vec(8'h04, 1'b0));
        tick();
        check("wsw_exec", exec_vec(8'h04, 16'hE000));
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wsw_go_low", idle_vec(8'h04, 1'b0));
        end
        Go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wsw_go_high", idle_vec(8'h04, 1'b0));
        end
        Go = 1'b0;
        n = 0;
        while (PC !== 8'h05 && n < 10) begin
            tick();
            n++;
            if (PC !== 8'h05) check("wsw_release_wait", idle_vec(8'h04, 1'b0));
        end
        nvec++;
        if (n != 3) begin
            nbad++;
            $display("FAIL wsw_release_latency: got %0d cycles expected 3", n);
        end
        check("wsw_resume_fetch", idle_vec(8'h05, 1'b0));
        tick();
        check("wsw_resume_exec", exec_vec(8'h05, 16'h2000));

        // Reset while in S_WAIT_LO.
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        Go = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("wait_lo_held", idle_vec(8'h04, 1'b0));
        Reset = 1'b1;
        Go = 1'b0;
        tick();
        check("rst_wait_lo", idle_vec(8'h00, 1'b0));
        Reset = 1'b0;
        tick();
        check("rst_wait_lo_exec", exec_vec(8'h00, 16'h2000));

        // JMP away, then JMP to self halts.
        fill_add();
        rom[3]    = 16'hC020;
        rom[8'h20] = 16'hC020;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        check("jmp_fetch", idle_vec(8'h03, 1'b0));
        tick();
        check("jmp_exec", exec_vec(8'h03, 16'hC020));
        tick();
        check("jmp_target", idle_vec(8'h20, 1'b0));
        tick();
        check("jmp_self_exec", exec_vec(8'h20, 16'hC020));
        tick();
        check("halt_entry", idle_vec(8'h20, 1'b1));
        for (int i = 0; i < 50; i++) begin
            Go = 1'($urandom);
            tick();
            check("halt_hold", idle_vec(8'h20, 1'b1));
        end
        Go = 1'b0;
        Reset = 1'b1;
        tick();
        check("rst_halt", idle_vec(8'h00, 1'b0));
        Reset = 1'b0;
        tick();
        check("rst_halt_exec", exec_vec(8'h00, 16'h2000));

        // PC wrap from 0xFF.
        fill_add();
        rom[0]     = 16'hC0FF;
        rom[8'hFF] = 16'h2000;
        do_reset();
        tick();
        check("wrap_jmp", exec_vec(8'h00, 16'hC0FF));
        tick();
        check("wrap_fetch_ff", idle_vec(8'hFF, 1'b0));
        tick();
        check("wrap_exec_ff", exec_vec(8'hFF, 16'h2000));
        tick();
        check("wrap_to_zero", idle_vec(8'h00, 1'b0));

        // Random programs without WSW or self-jumps, against an instruction-level model.
        for (int a = 0; a < 256; a++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'd7) w[15:13] = 3'd1;
            if (w[15:13] == 3'd6 && w[7:0] == 8'(a)) w[7:0] = 8'(a + 1);
            rom[a] = w;
        end
        do_reset();
        pc = 8'h00;
        for (int k = 0; k < 200; k++) begin
            Go = 1'($urandom);
            tick();
            check("rand_exec", exec_vec(pc, rom[pc]));
            npc = (rom[pc][15:13] == 3'd6) ? rom[pc][7:0] : pc + 8'd1;
            Go = 1'($urandom);
            tick();
            check("rand_fetch", idle_vec(npc, 1'b0));
            pc = npc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning the program-counter and program-ROM address width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning the register-file address width.
REQ-003 SHALL have port Clock, input, 1, the single rising-edge clock.
REQ-004 SHALL have port Reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port Instr, input, 16, program ROM data, valid one cycle after PC changes.
REQ-006 SHALL have port Go, input, 1, asynchronous operator handshake (switch SW[8]).
REQ-007 SHALL have port PC, output, PC_W, program ROM address.
REQ-008 SHALL have port Func, output, 3, ALU opcode.
REQ-009 SHALL have port Imm, output, 8, signed immediate, equal to Instr[7:0].
REQ-010 SHALL have port RegAddr, output, REG_AW, register-file address, equal to Instr[12:8].
REQ-011 SHALL have ports AluWE, SelSW, SelImm, RegWE and Halted, each output, 1: ALU accumulator write, ALU switch-source select, ALU immediate-source select, register write-back strobe, and halt flag.

Function
REQ-012 SHALL decode Instr[15:13] as the opcode: RTA=000, ADD=001, LSW=010, ADDI=011, ATR=100, MULI=101, JMP=110, WSW=111.
REQ-013 SHALL implement FSM states S_FETCH, S_EXEC, S_WAIT_HI, S_WAIT_LO and S_HALT.
REQ-014 SHALL make S_FETCH last exactly one cycle with all strobes low and PC stable, then go to S_EXEC.
REQ-015 SHALL in S_EXEC drive Func=opcode, Imm=Instr[7:0] and RegAddr=Instr[12:8] combinationally from Instr.
REQ-016 SHALL in S_EXEC assert AluWE for exactly one cycle for RTA, ADD, LSW, ADDI and MULI.
REQ-017 SHALL assert SelSW only for LSW in S_EXEC, and SelImm only for ADDI and MULI in S_EXEC.
REQ-018 SHALL in S_EXEC for ATR assert RegWE for one cycle with AluWE low.
REQ-019 SHALL for every non-JMP, non-WSW opcode set PC <= PC+1 at the end of S_EXEC and return to S_FETCH, giving two cycles per instruction.
REQ-020 SHALL let PC wrap from 2^PC_W-1 to 0 with no flag.
REQ-021 SHALL for JMP set PC <= Imm[PC_W-1:0].
REQ-022 SHALL for JMP whose target equals the current PC go to S_HALT with Halted=1.
REQ-023 SHALL hold S_HALT until Reset, with all strobes low.
REQ-024 SHALL for WSW go to S_WAIT_HI and keep all strobes low while waiting.
REQ-025 SHALL in S_WAIT_HI move to S_WAIT_LO when synchronized Go=1.
REQ-026 SHALL in S_WAIT_LO, when synchronized Go=0, set PC <= PC+1 and return to S_FETCH.
REQ-027 SHALL take Go through a 2-flop synchronizer, so any Go change is seen no earlier than 2 cycles later.
REQ-028 SHALL ignore a Go pulse shorter than 2 cycles only if the synchronizer misses it; there SHALL be no other glitch filtering.
REQ-029 SHALL have no hazards between consecutive instructions: ALU results are committed before the next S_EXEC.

Reset
REQ-030 SHALL on Reset=1 at a clock edge set PC=0, state=S_FETCH, both synchronizer flops=0 and Halted=0, from any state including mid-wait and halt.
REQ-031 SHALL hold AluWE, RegWE, SelSW, SelImm low while Reset is high and in the first S_FETCH after it.
REQ-032 SHALL hold Func, Imm and RegAddr at 0 outside S_EXEC.

Structure
REQ-033 SHALL place the OP_* constants and the state enum typedef in shared package picomips_pkg, which the ALU also uses.
REQ-034 SHALL implement the Go synchronizer as sub-module go_sync (Clock, Reset, async_in, sync_out).

Verification
REQ-035 SHALL cover: reset then Instr=ADDI r0 #5 (0x6005) -> cycle 1 all strobes 0, PC=0; cycle 2 AluWE=1, SelImm=1, Func=011, Imm=5; cycle 3 PC=1.
REQ-036 SHALL cover: ATR with RegAddr=7 (0x8700) -> RegWE=1 for exactly one cycle, AluWE=0, RegAddr=7.
REQ-037 SHALL cover: WSW at PC=4, Go held 0 for 10 cycles, then 1 for 3 cycles, then 0 -> PC stays 4 and strobes stay 0 until 2 cycles after Go falls, then PC=5.
REQ-038 SHALL cover: JMP 0x20 at PC=3 -> PC=0x20; JMP 0x20 at PC=0x20 -> Halted=1 and PC frozen for 50 cycles.
REQ-039 SHALL cover: PC=0xFF executing ADD -> next PC=0x00.
REQ-040 SHALL cover: Reset asserted in S_WAIT_LO and in S_HALT -> next cycle PC=0, Halted=0, S_FETCH.
